// File: rtl/imem_loader_pkg.sv
// Shared encodings and stream-format constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_HDR_HI = 3'd0;
  localparam state_t ST_HDR_LO = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_CSUM   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;
  localparam state_t ST_ERROR  = 3'd5;

  localparam int HDR_LEN    = 2;
  localparam int WORD_BYTES = 4;

  // States in which the loader is willing to take a stream byte.
  function automatic logic is_receiving(input state_t s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream, instruction-memory write port and core-reset status bundled for the loader.
interface imem_loader_if #(parameter int ADDR_W = 10);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;

  modport master (
    output in_data, in_valid, reload,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, load_err
  );

  modport slave (
    input  in_data, in_valid, reload,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, load_err
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs big-endian bytes into 32-bit words; word_valid is a registered one-cycle pulse.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [23:0] shreg;

  assign word_last = byte_en && (idx == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= 2'd0;
      shreg      <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      word_valid <= word_last;
      if (clr) begin
        idx   <= 2'd0;
        shreg <= 24'd0;
      end else if (byte_en) begin
        shreg <= {shreg[15:0], byte_in};
        idx   <= idx + 2'd1;
        if (word_last)
          word <= {shreg, byte_in};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses the image header, streams words into instruction memory,
// checks the XOR checksum and holds the core in reset until a good image is in place.
//
// state  | meaning
// HDR_HI | waiting for word-count high byte
// HDR_LO | waiting for word-count low byte
// DATA   | receiving N words, 4 bytes each, MSB first
// CSUM   | waiting for checksum byte
// DONE   | image good, core released
// ERROR  | image rejected, core held in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
)
(
  input logic         clk,
  input logic         pc_rst,
  imem_loader_if.slave bus
);

  localparam logic [16:0]       CAP  = 17'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state, state_nxt;
  logic [7:0]        hdr_hi, xor_acc;
  logic [16:0]       n_hdr, n_words, word_cnt;
  logic [ADDR_W-1:0] wr_addr, addr_q;
  logic              in_ready_q, cpu_rst_q, done_q, err_q;
  logic              accept, byte_en, restart, word_last, word_valid;
  logic [31:0]       word;

  assign accept  = bus.in_valid & in_ready_q;
  assign byte_en = accept && (state == ST_DATA);
  assign restart = bus.reload && ((state == ST_DONE) || (state == ST_ERROR));
  assign n_hdr   = {1'b0, hdr_hi, bus.in_data};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HDR_HI: if (accept) state_nxt = ST_HDR_LO;
      ST_HDR_LO: if (accept) begin
        if (n_hdr > CAP)        state_nxt = ST_ERROR;
        else if (n_hdr == 17'd0) state_nxt = ST_CSUM;
        else                    state_nxt = ST_DATA;
      end
      ST_DATA:   if (word_last && (word_cnt + 17'd1 == n_words)) state_nxt = ST_CSUM;
      ST_CSUM:   if (accept) state_nxt = (bus.in_data == xor_acc) ? ST_DONE : ST_ERROR;
      ST_DONE,
      ST_ERROR:  if (bus.reload) state_nxt = ST_HDR_HI;
      default:   state_nxt = ST_HDR_HI;
    endcase
  end

  // Status outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      state      <= ST_HDR_HI;
      in_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hdr_hi     <= 8'd0;
      xor_acc    <= 8'd0;
      n_words    <= 17'd0;
      word_cnt   <= 17'd0;
      wr_addr    <= BASE;
      addr_q     <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= is_receiving(state_nxt);
      cpu_rst_q  <= (state_nxt != ST_DONE);
      done_q     <= (state_nxt == ST_DONE);
      err_q      <= (state_nxt == ST_ERROR);
      if (restart) begin
        xor_acc  <= 8'd0;
        word_cnt <= 17'd0;
        wr_addr  <= BASE;
      end else if (accept) begin
        if (state != ST_CSUM)   xor_acc <= xor_acc ^ bus.in_data;
        if (state == ST_HDR_HI) hdr_hi  <= bus.in_data;
        if (state == ST_HDR_LO) n_words <= n_hdr;
        if (word_last) begin
          addr_q   <= wr_addr;
          wr_addr  <= wr_addr + ADDR_W'(1);
          word_cnt <= word_cnt + 17'd1;
        end
      end
    end
  end

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (pc_rst),
    .clr        (restart),
    .byte_en    (byte_en),
    .byte_in    (bus.in_data),
    .word_last  (word_last),
    .word_valid (word_valid),
    .word       (word)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.load_done  = done_q;
  assign bus.load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for a 2-word image plus multi-cycle corner sequences.
module tb_imem_loader;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk;
  logic pc_rst;

  imem_loader_if #(.ADDR_W(10)) bif ();

  imem_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk    (clk),
    .pc_rst (pc_rst),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    logic        vld;
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        cpu;
    logic        done;
    logic        err;
  } vec_t;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t       vt [12];
  wr_t        wq [$];
  logic [7:0] img [$];
  int         total  = 0;
  int         passed = 0;

  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic r, input logic w,
                              input logic [9:0] a, input logic [31:0] wd,
                              input logic c, input logic dn, input logic e);
    vec_t x;
    x.din = d; x.vld = v; x.rdy = r; x.we = w; x.addr = a; x.wdata = wd;
    x.cpu = c; x.done = dn; x.err = e;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

  always @(negedge clk)
    if (bif.imem_we === 1'b1) wq.push_back('{bif.imem_addr, bif.imem_wdata});

  task automatic check_wr(input int idx, input logic [9:0] a, input logic [31:0] d);
    if (idx < wq.size()) begin
      chk("wr_addr", {22'd0, wq[idx].a}, {22'd0, a});
      chk("wr_data", wq[idx].d, d);
    end else begin
      chk("wr_missing", wq.size(), idx + 1);
    end
  endtask

  // Sends img[] byte by byte; returns #1 after the edge that accepted the last byte.
  task automatic send_img(input bit rand_valid);
    int i = 0;
    int cyc = 0;
    logic rdy, v;
    while (i < img.size() && cyc < 200) begin
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      bif.in_data  = img[i];
      bif.in_valid = v;
      rdy = bif.in_ready;
      @(posedge clk);
      #1;
      if (v && rdy) i++;
      cyc++;
    end
    bif.in_valid = 1'b0;
    chk("bytes_accepted", i, img.size());
  endtask

  task automatic pulse_reload();
    bif.reload = 1'b1;
    @(posedge clk);
    #1;
    bif.reload = 1'b0;
    chk("reload_cpu_rst", {31'd0, bif.cpu_rst}, 32'd1);
    chk("reload_done_clr", {31'd0, bif.load_done}, 32'd0);
    chk("reload_err_clr", {31'd0, bif.load_err}, 32'd0);
    chk("reload_ready", {31'd0, bif.in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pc_rst = 1'b0;
    bif.in_data = 8'h00;
    bif.in_valid = 1'b0;
    bif.reload = 1'b0;
    #2 pc_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bif.in_ready}, 32'd0);
    chk("rst_we", {31'd0, bif.imem_we}, 32'd0);
    chk("rst_addr", {22'd0, bif.imem_addr}, 32'd0);
    chk("rst_wdata", bif.imem_wdata, 32'd0);
    chk("rst_cpu_rst", {31'd0, bif.cpu_rst}, 32'd1);
    chk("rst_done", {31'd0, bif.load_done}, 32'd0);
    chk("rst_err", {31'd0, bif.load_err}, 32'd0);
    pc_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {31'd0, bif.in_ready}, 32'd1);

    // Good N=2 image, one byte per cycle, checked cycle by cycle.
    vt[0]  = mk(8'h00, H, H, L, 10'd0, 32'h0, H, L, L);
    vt[1]  = mk(8'h02, H, H, L, 10'd0, 32'h0, H, L, L);
    vt[2]  = mk(8'h3C, H, H, L, 10'd0, 32'h0, H, L, L);
    vt[3]  = mk(8'h01, H, H, L, 10'd0, 32'h0, H, L, L);
    vt[4]  = mk(8'h00, H, H, L, 10'd0, 32'h0, H, L, L);
    vt[5]  = mk(8'h01, H, H, H, 10'd0, 32'h3C010001, H, L, L);
    vt[6]  = mk(8'h20, H, H, L, 10'd0, 32'h0, H, L, L);
    vt[7]  = mk(8'h22, H, H, L, 10'd0, 32'h0, H, L, L);
    vt[8]  = mk(8'h00, H, H, L, 10'd0, 32'h0, H, L, L);
    vt[9]  = mk(8'h05, H, H, H, 10'd1, 32'h20220005, H, L, L);
    vt[10] = mk(8'h39, H, L, L, 10'd0, 32'h0, L, H, L);
    vt[11] = mk(8'h00, L, L, L, 10'd0, 32'h0, L, H, L);
    wq.delete();
    for (int k = 0; k < 12; k++) begin
      bif.in_data  = vt[k].din;
      bif.in_valid = vt[k].vld;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ready", k), {31'd0, bif.in_ready}, {31'd0, vt[k].rdy});
      chk($sformatf("v%0d_we", k), {31'd0, bif.imem_we}, {31'd0, vt[k].we});
      chk($sformatf("v%0d_cpu_rst", k), {31'd0, bif.cpu_rst}, {31'd0, vt[k].cpu});
      chk($sformatf("v%0d_done", k), {31'd0, bif.load_done}, {31'd0, vt[k].done});
      chk($sformatf("v%0d_err", k), {31'd0, bif.load_err}, {31'd0, vt[k].err});
      if (vt[k].we) begin
        chk($sformatf("v%0d_addr", k), {22'd0, bif.imem_addr}, {22'd0, vt[k].addr});
        chk($sformatf("v%0d_wdata", k), bif.imem_wdata, vt[k].wdata);
      end
    end
    bif.in_valid = 1'b0;
    chk("a_wr_count", wq.size(), 2);

    // Reload from DONE, then the same image with a corrupted checksum.
    pulse_reload();
    img = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20, 8'h22, 8'h00, 8'h05, 8'h38};
    send_img(1'b0);
    chk("bad_err", {31'd0, bif.load_err}, 32'd1);
    chk("bad_cpu_rst", {31'd0, bif.cpu_rst}, 32'd1);
    chk("bad_ready", {31'd0, bif.in_ready}, 32'd0);
    chk("bad_done", {31'd0, bif.load_done}, 32'd0);

    // Empty image: N=0, checksum 0.
    pulse_reload();
    wq.delete();
    img = '{8'h00, 8'h00, 8'h00};
    send_img(1'b0);
    chk("n0_done", {31'd0, bif.load_done}, 32'd1);
    chk("n0_cpu_rst", {31'd0, bif.cpu_rst}, 32'd0);
    chk("n0_no_write", wq.size(), 0);

    // Oversized count rejected right after the low byte.
    pulse_reload();
    img = '{8'h04, 8'h01};
    send_img(1'b0);
    chk("big_err", {31'd0, bif.load_err}, 32'd1);
    chk("big_ready", {31'd0, bif.in_ready}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("big_no_write", wq.size(), 0);

    // Good image with in_valid toggling randomly.
    pulse_reload();
    img = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20, 8'h22, 8'h00, 8'h05, 8'h39};
    send_img(1'b1);
    chk("rnd_done", {31'd0, bif.load_done}, 32'd1);
    chk("rnd_cpu_rst", {31'd0, bif.cpu_rst}, 32'd0);
    chk("rnd_wr_count", wq.size(), 2);
    check_wr(0, 10'd0, 32'h3C010001);
    check_wr(1, 10'd1, 32'h20220005);

    // Abort with pc_rst after 5 data bytes, then a fresh image must start at address 0.
    pulse_reload();
    wq.delete();
    img = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h01, 8'h20};
    send_img(1'b0);
    chk("part_wr_count", wq.size(), 1);
    pc_rst = 1'b1;
    #1;
    chk("abort_cpu_rst", {31'd0, bif.cpu_rst}, 32'd1);
    chk("abort_ready", {31'd0, bif.in_ready}, 32'd0);
    chk("abort_we", {31'd0, bif.imem_we}, 32'd0);
    repeat (2) @(negedge clk);
    pc_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready_back", {31'd0, bif.in_ready}, 32'd1);
    wq.delete();
    img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    send_img(1'b0);
    chk("post_abort_done", {31'd0, bif.load_done}, 32'd1);
    chk("post_abort_wr_count", wq.size(), 1);
    check_wr(0, 10'd0, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
